// File: rtl/regfile_sb.sv
// General-purpose register file with two registered read ports, one write-back
// port with same-cycle bypass, and a pending-result scoreboard for hazard stalls.
module regfile_sb #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic [AW-1:0]    rs_a_sel,
    input  logic [AW-1:0]    rs_b_sel,
    output logic [WIDTH-1:0] rs_a,
    output logic [WIDTH-1:0] rs_b,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_sel,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_sel,
    input  logic [WIDTH-1:0] wb_data,
    output logic             hazard,
    output logic [AW:0]      pend_cnt
);

    localparam bit ZR = (ZERO_REG != 0);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_nxt;
    logic [DEPTH-1:0] wb_mask;
    logic [DEPTH-1:0] eff;
    logic [WIDTH-1:0] a_nxt;
    logic [WIDTH-1:0] b_nxt;
    logic             wr_ok;
    logic             set_ok;
    logic [AW:0]      cnt;

    assign wr_ok  = wb_en  && !(ZR && (wb_sel == '0));
    assign set_ok = iss_en && !(ZR && (iss_sel == '0));

    // Bypass first, then the hard-wired zero register overrides everything.
    always_comb begin
        a_nxt = regs[rs_a_sel];
        if (wb_en && (wb_sel == rs_a_sel)) a_nxt = wb_data;
        if (ZR && (rs_a_sel == '0))        a_nxt = '0;
        b_nxt = regs[rs_b_sel];
        if (wb_en && (wb_sel == rs_b_sel)) b_nxt = wb_data;
        if (ZR && (rs_b_sel == '0))        b_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= (i == 1) ? '1 : '0;
            end
        end else if (wr_ok) begin
            regs[wb_sel] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs_a <= '0;
            rs_b <= '0;
        end else if (rd_en) begin
            rs_a <= a_nxt;
            rs_b <= b_nxt;
        end
    end

    // Set after clear so a same-cycle issue to the written register keeps it pending.
    always_comb begin
        pending_nxt = pending;
        if (wb_en)  pending_nxt[wb_sel]  = 1'b0;
        if (set_ok) pending_nxt[iss_sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else     pending <= pending_nxt;
    end

    assign wb_mask = wb_en ? (DEPTH'(1) << wb_sel) : '0;
    assign eff     = pending & ~wb_mask;
    assign hazard  = eff[rs_a_sel] | eff[rs_b_sel] | (iss_en & eff[iss_sel]);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + {{AW{1'b0}}, pending[i]};
        end
    end

    assign pend_cnt = cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: table-driven vectors on the default 16x8 instance plus
// a hand-written sequence on a 32x16 instance, checked through a result queue.
module tb_regfile_sb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // default instance
    logic        rd_en = 0, iss_en = 0, wb_en = 0;
    logic [2:0]  rs_a_sel = 0, rs_b_sel = 0, iss_sel = 0, wb_sel = 0;
    logic [15:0] wb_data = 0;
    logic [15:0] rs_a, rs_b;
    logic        hazard;
    logic [3:0]  pend_cnt;

    regfile_sb #(.WIDTH(16), .DEPTH(8), .AW(3), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rs_a_sel(rs_a_sel), .rs_b_sel(rs_b_sel),
        .rs_a(rs_a), .rs_b(rs_b), .iss_en(iss_en), .iss_sel(iss_sel), .wb_en(wb_en),
        .wb_sel(wb_sel), .wb_data(wb_data), .hazard(hazard), .pend_cnt(pend_cnt));

    // wide instance
    logic        w_rd_en = 0, w_iss_en = 0, w_wb_en = 0;
    logic [3:0]  w_a_sel = 0, w_b_sel = 0, w_iss_sel = 0, w_wb_sel = 0;
    logic [31:0] w_wb_data = 0;
    logic [31:0] w_rs_a, w_rs_b;
    logic        w_hazard;
    logic [4:0]  w_pend_cnt;

    regfile_sb #(.WIDTH(32), .DEPTH(16), .AW(4), .ZERO_REG(1)) dut_w (
        .clk(clk), .rst(rst), .rd_en(w_rd_en), .rs_a_sel(w_a_sel), .rs_b_sel(w_b_sel),
        .rs_a(w_rs_a), .rs_b(w_rs_b), .iss_en(w_iss_en), .iss_sel(w_iss_sel), .wb_en(w_wb_en),
        .wb_sel(w_wb_sel), .wb_data(w_wb_data), .hazard(w_hazard), .pend_cnt(w_pend_cnt));

    typedef struct {
        logic        rst;
        logic        rd;
        logic [2:0]  a;
        logic [2:0]  b;
        logic        iss;
        logic [2:0]  isel;
        logic        wb;
        logic [2:0]  wsel;
        logic [15:0] wdata;
        logic        hz;     // expected hazard before the edge
        logic [15:0] ea;     // expected rs_a after the edge
        logic [15:0] eb;
        logic [3:0]  ecnt;   // expected pend_cnt after the edge
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic rd, input int a, input int b,
                                input logic iss, input int isel, input logic wb, input int wsel,
                                input logic [15:0] wdata, input logic hz, input logic [15:0] ea,
                                input logic [15:0] eb, input int ecnt);
        vec_t v;
        v.rst = r; v.rd = rd; v.a = 3'(a); v.b = 3'(b);
        v.iss = iss; v.isel = 3'(isel); v.wb = wb; v.wsel = 3'(wsel); v.wdata = wdata;
        v.hz = hz; v.ea = ea; v.eb = eb; v.ecnt = 4'(ecnt);
        return v;
    endfunction

    task automatic apply(input int idx, input vec_t v);
        exp_t e;
        @(negedge clk);
        rst = v.rst; rd_en = v.rd; rs_a_sel = v.a; rs_b_sel = v.b;
        iss_en = v.iss; iss_sel = v.isel; wb_en = v.wb; wb_sel = v.wsel; wb_data = v.wdata;
        #1;
        chk($sformatf("v%0d hazard", idx), {31'd0, hazard}, {31'd0, v.hz});
        sb.push_back('{a: {16'd0, v.ea}, b: {16'd0, v.eb}, cnt: {1'b0, v.ecnt}});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk($sformatf("v%0d rs_a", idx), {16'd0, rs_a}, e.a);
        chk($sformatf("v%0d rs_b", idx), {16'd0, rs_b}, e.b);
        chk($sformatf("v%0d pend_cnt", idx), {28'd0, pend_cnt}, {27'd0, e.cnt});
    endtask

    initial begin
        exp_t e;
        //            rst rd a  b  iss is wb ws wdata     hz  ea       eb       cnt
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'hFFFF, 0));
        vecs.push_back(mk(0, 1, 3, 1, 0, 0, 1, 3, 16'h1234, 0, 16'h1234, 16'hFFFF, 0));
        vecs.push_back(mk(0, 1, 2, 3, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h1234, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 16'hBEEF, 0, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'hFFFF, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'hFFFF, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 5, 0, 0, 16'h0000, 0, 16'h0000, 16'hFFFF, 1));
        vecs.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'hFFFF, 1));
        vecs.push_back(mk(0, 1, 5, 1, 0, 0, 1, 5, 16'h0055, 0, 16'h0055, 16'hFFFF, 0));
        vecs.push_back(mk(0, 0, 2, 1, 1, 5, 1, 5, 16'h0066, 0, 16'h0055, 16'hFFFF, 1));
        vecs.push_back(mk(0, 1, 1, 5, 0, 0, 0, 0, 16'h0000, 1, 16'hFFFF, 16'h0066, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 5, 0, 0, 16'h0000, 1, 16'hFFFF, 16'h0066, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4, 16'h0444, 0, 16'hFFFF, 16'h0066, 1));
        vecs.push_back(mk(0, 1, 4, 5, 0, 0, 1, 5, 16'h0555, 0, 16'h0444, 16'h0555, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0, 16'h0000, 0, 16'h0444, 16'h0555, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 4, 0, 0, 16'h0000, 0, 16'h0444, 16'h0555, 2));
        vecs.push_back(mk(0, 0, 2, 0, 1, 6, 0, 0, 16'h0000, 1, 16'h0444, 16'h0555, 3));
        vecs.push_back(mk(1, 1, 3, 1, 1, 7, 1, 3, 16'hAAAA, 0, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 1, 1, 3, 0, 0, 0, 0, 16'h0000, 0, 16'hFFFF, 16'h0000, 0));
        vecs.push_back(mk(0, 1, 5, 4, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 1, 2, 4, 1, 2, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset rs_a", {16'd0, rs_a}, 32'd0);
        chk("reset rs_b", {16'd0, rs_b}, 32'd0);
        chk("reset pend_cnt", {28'd0, pend_cnt}, 32'd0);
        chk("reset hazard", {31'd0, hazard}, 32'd0);

        foreach (vecs[i]) apply(i, vecs[i]);

        // wide instance: write the top register, read it back, then fill the scoreboard
        @(negedge clk);
        w_wb_en = 1'b1; w_wb_sel = 4'd15; w_wb_data = 32'hDEADBEEF;
        @(negedge clk);
        w_wb_en = 1'b0; w_rd_en = 1'b1; w_a_sel = 4'd15; w_b_sel = 4'd1;
        sb.push_back('{a: 32'hDEADBEEF, b: 32'hFFFFFFFF, cnt: 5'd0});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("wide rs_a", w_rs_a, e.a);
        chk("wide rs_b", w_rs_b, e.b);
        chk("wide pend_cnt", {27'd0, w_pend_cnt}, {27'd0, e.cnt});
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            w_rd_en = 1'b0; w_iss_en = 1'b1; w_iss_sel = 4'(i);
        end
        @(negedge clk);
        w_iss_en = 1'b0; w_a_sel = 4'd15; w_b_sel = 4'd0;
        #1;
        chk("wide pend_cnt full", {27'd0, w_pend_cnt}, 32'd15);
        chk("wide hazard", {31'd0, w_hazard}, 32'd1);
        w_wb_en = 1'b1; w_wb_sel = 4'd15; w_wb_data = 32'h0;
        #1;
        chk("wide hazard bypass", {31'd0, w_hazard}, 32'd0);
        @(posedge clk);
        #1;
        chk("wide pend_cnt after wb", {27'd0, w_pend_cnt}, 32'd14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file for the tiny16 datapath, with a write-back scoreboard. It provides two registered read ports and one write-back port, with same-cycle write-to-read bypass. A per-register pending bit tracks in-flight results so the decode stage can stall on RAW and WAW hazards. It sits between decode (read and issue) and write-back, and replaces the fixed 8x16 file.

## Interface
Parameters:
- WIDTH, 16, register width in bits
- DEPTH, 8, number of registers (power of two, 2..32)
- AW, 3, select width; equals log2(DEPTH)
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes and issues

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rd_en  in  1  capture read ports this cycle
- rs_a_sel  in  AW  read port A select
- rs_b_sel  in  AW  read port B select
- rs_a  out  WIDTH  registered read data A
- rs_b  out  WIDTH  registered read data B
- iss_en  in  1  decode issues an instruction writing iss_sel (sets pending)
- iss_sel  in  AW  destination of issued instruction
- wb_en  in  1  write-back strobe
- wb_sel  in  AW  write-back destination
- wb_data  in  WIDTH  write-back data
- hazard  out  1  combinational stall request
- pend_cnt  out  AW+1  number of registers currently pending

## Operation
- Reset values:
  - reg 0 = 0, reg 1 = all ones, all other registers = 0.
  - rs_a = rs_b = 0; all pending bits clear, pend_cnt = 0.
  - rst has priority over every other input, including mid-operation; in-flight scoreboard state is discarded.
- Write: when wb_en is high, reg[wb_sel] <= wb_data at the edge. With ZERO_REG=1 and wb_sel=0, nothing is written.
- Read: when rd_en is high, rs_a <= reg[rs_a_sel] and rs_b <= reg[rs_b_sel]. When rd_en is low, both outputs hold.
- Bypass: if wb_en is high and wb_sel equals a read select in the same cycle, that port captures wb_data, not the old contents. With ZERO_REG=1, select 0 always reads 0.
- Scoreboard:
  - iss_en sets pending[iss_sel]; wb_en clears pending[wb_sel].
  - When both hit the same register in one cycle, set wins: a new producer exists.
  - With ZERO_REG=1, index 0 is never set.
- Write-back to a register that is not pending is a legal write. It leaves pending unchanged and must not underflow pend_cnt.
- hazard = effA | effB | (iss_en & effI), where eff[x] = pending[x] & !(wb_en & wb_sel==x).
  - A same-cycle write-back satisfies the dependency through the bypass.
  - hazard does not gate iss_en internally. The decoder must not raise iss_en while hazard is high; if it does, the set is still applied.
- pend_cnt is the population count of the pending bits, updated on the same edge as the bits.

## Timing
- Read latency is 1 cycle: selects sampled at edge N appear on rs_a/rs_b after edge N.
- Write-to-read latency is 0 cycles via the bypass; the register array itself updates at the same edge.
- Pending set/clear is visible on hazard in the cycle after the edge.
- hazard is combinational from the selects, iss_en/iss_sel, wb_en/wb_sel and the pending bits; there is no registered path.
- Throughput: one read pair, one issue and one write-back per cycle, all independent.

## Test plan
- Reset, then rd_en with rs_a_sel=0 and rs_b_sel=1 -> rs_a=0x0000 and rs_b=0xFFFF one cycle later; pend_cnt=0 and hazard=0.
- wb_en, wb_sel=3, wb_data=0x1234, with rd_en and rs_a_sel=3 in the same cycle -> rs_a=0x1234 next cycle (bypass). A later read of reg 3 also returns 0x1234.
- Write-back to reg 0 with wb_data=0xBEEF and ZERO_REG=1 -> reg 0 reads 0x0000. Issue to reg 0 -> pend_cnt stays 0.
- Scoreboard sequence:
  - Issue to reg 5 -> next cycle, rs_a_sel=5 gives hazard=1 and pend_cnt=1.
  - Write-back to reg 5 in a later cycle -> hazard=0 in that same cycle; pend_cnt=0 after the edge.
  - Issue and write-back to reg 5 in the same cycle -> pending stays set.
- Issue to regs 2, 4 and 6, then assert rst mid-stream with wb_en=1 -> all pending bits clear, pend_cnt=0, rs_a=rs_b=0, and regs hold their reset values.
- Instance with WIDTH=32 and DEPTH=16 -> write 0xDEADBEEF to reg 15 and read it back (captures 0xDEADBEEF). Issue to all 15 nonzero registers -> pend_cnt=15.
